// File: rtl/lag_correlator_core.sv
// rtl/lag_correlator_core.sv - pairwise lag coincidence correlator with framed word readout
module lag_correlator_core #(
    parameter int NUM_INPUTS    = 14,
    parameter int MAX_DELAY     = 1,
    parameter int RESOLUTION    = 12,
    parameter int SAMPLE_DIV    = 25,
    parameter int INTEG_SAMPLES = 100000,
    parameter logic [NUM_INPUTS-1:0] INVERT_MASK = '1
) (
    input  logic                  clki,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] pulse_in,
    output logic                  sample_clk_pulse,
    output logic                  integration_clk_pulse,
    output logic [RESOLUTION-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  overrun
);

    localparam int NL        = 2 * MAX_DELAY + 1;
    localparam int NUM_PAIRS = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
    localparam int NUM_WORDS = NUM_PAIRS * NL;
    localparam int DIV_W     = $clog2(SAMPLE_DIV);
    localparam int WIN_W     = $clog2(INTEG_SAMPLES);
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int DL_N      = (MAX_DELAY > 0) ? MAX_DELAY : 1;
    localparam logic [RESOLUTION-1:0] CNT_MAX = '1;

    typedef enum logic {IDLE, STREAM} state_t;

    logic [NUM_INPUTS-1:0] sync1, sync2, x;
    logic [DIV_W-1:0]      div;
    logic [WIN_W-1:0]      win;
    logic                  tick, win_end, snapshot, at_last, accept;
    logic [NUM_INPUTS-1:0] dl   [DL_N];
    logic [NUM_INPUTS-1:0] taps [MAX_DELAY+1];
    logic [NUM_WORDS-1:0]  hit;
    logic [RESOLUTION-1:0] cnt     [NUM_WORDS];
    logic [RESOLUTION-1:0] cnt_nxt [NUM_WORDS];
    logic [RESOLUTION-1:0] shadow  [NUM_WORDS];
    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;

    assign x        = sync2 ^ INVERT_MASK;
    assign tick     = (div == DIV_W'(SAMPLE_DIV - 1));
    assign win_end  = tick && (win == WIN_W'(INTEG_SAMPLES - 1));
    assign snapshot = win_end && (state == IDLE);
    assign at_last  = (idx == IDX_W'(NUM_WORDS - 1));
    assign accept   = (state == STREAM) && out_ready;

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pulse_in;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            div                   <= '0;
            win                   <= '0;
            sample_clk_pulse      <= 1'b0;
            integration_clk_pulse <= 1'b0;
        end else begin
            sample_clk_pulse      <= tick;
            integration_clk_pulse <= win_end;
            if (tick) begin
                div <= '0;
                win <= win_end ? '0 : win + WIN_W'(1);
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    // taps[0] is the sample being taken now, taps[k] the sample k ticks ago
    always_comb begin
        taps[0] = x;
        for (int k = 1; k <= MAX_DELAY; k++) taps[k] = dl[k-1];
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DL_N; k++) dl[k] <= '0;
        end else if (tick) begin
            for (int k = 0; k < DL_N; k++) dl[k] <= taps[k];
        end
    end

    for (genvar i = 0; i < NUM_INPUTS - 1; i++) begin : g_i
        for (genvar j = i + 1; j < NUM_INPUTS; j++) begin : g_j
            localparam int P = i * NUM_INPUTS - i * (i + 1) / 2 + (j - i - 1);
            for (genvar k = 0; k < NL; k++) begin : g_k
                localparam int D = k - MAX_DELAY;
                if (D >= 0) begin : g_pos
                    assign hit[P*NL+k] = taps[D][i] & taps[0][j];
                end else begin : g_neg
                    assign hit[P*NL+k] = taps[0][i] & taps[-D][j];
                end
            end
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WORDS; w++)
            cnt_nxt[w] = (hit[w] && cnt[w] != CNT_MAX) ? cnt[w] + RESOLUTION'(1) : cnt[w];
    end

    // the shadow bank only reloads when the previous frame has fully drained
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                cnt[w]    <= '0;
                shadow[w] <= '0;
            end
        end else if (tick) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                cnt[w] <= win_end ? '0 : cnt_nxt[w];
                if (snapshot) shadow[w] <= cnt_nxt[w];
            end
        end
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (win_end && state == STREAM) begin
            overrun <= 1'b1;
        end
    end

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (snapshot) begin
                    state_nxt = STREAM;
                    idx_nxt   = '0;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (at_last) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = (state == STREAM);
        out_last  = (state == STREAM) && at_last;
        out_data  = shadow[idx];
    end

endmodule

// File: tb/tb_lag_correlator_core.sv
// tb/tb_lag_correlator_core.sv - self-checking bench for lag_correlator_core
module tb_lag_correlator_core;

    logic clki = 1'b0;
    always #5 clki = ~clki;

    logic       rst_n;
    logic [2:0] pulse;
    logic       ready;

    logic       a_sp, a_ip, a_v, a_l, a_ov;
    logic       b_sp, b_ip, b_v, b_l, b_ov;
    logic       c_sp, c_ip, c_v, c_l, c_ov;
    logic [3:0] a_d, b_d, c_d;

    lag_correlator_core #(.NUM_INPUTS(3), .MAX_DELAY(1), .RESOLUTION(4), .SAMPLE_DIV(4),
                          .INTEG_SAMPLES(8), .INVERT_MASK(3'b000)) dut_a (
        .clki(clki), .rst_n(rst_n), .pulse_in(pulse), .sample_clk_pulse(a_sp),
        .integration_clk_pulse(a_ip), .out_data(a_d), .out_valid(a_v), .out_ready(ready),
        .out_last(a_l), .overrun(a_ov));

    lag_correlator_core #(.NUM_INPUTS(3), .MAX_DELAY(1), .RESOLUTION(4), .SAMPLE_DIV(4),
                          .INTEG_SAMPLES(20), .INVERT_MASK(3'b000)) dut_b (
        .clki(clki), .rst_n(rst_n), .pulse_in(pulse), .sample_clk_pulse(b_sp),
        .integration_clk_pulse(b_ip), .out_data(b_d), .out_valid(b_v), .out_ready(ready),
        .out_last(b_l), .overrun(b_ov));

    lag_correlator_core #(.NUM_INPUTS(3), .MAX_DELAY(1), .RESOLUTION(4), .SAMPLE_DIV(4),
                          .INTEG_SAMPLES(8), .INVERT_MASK(3'b111)) dut_c (
        .clki(clki), .rst_n(rst_n), .pulse_in(pulse), .sample_clk_pulse(c_sp),
        .integration_clk_pulse(c_ip), .out_data(c_d), .out_valid(c_v), .out_ready(ready),
        .out_last(c_l), .overrun(c_ov));

    // all three instances share stimulus; sel picks the one under observation
    logic [1:0] sel;
    logic       o_sp, o_ip, o_v, o_l, o_ov;
    logic [3:0] o_d;
    assign o_sp = (sel == 2'd1) ? b_sp : (sel == 2'd2) ? c_sp : a_sp;
    assign o_ip = (sel == 2'd1) ? b_ip : (sel == 2'd2) ? c_ip : a_ip;
    assign o_v  = (sel == 2'd1) ? b_v  : (sel == 2'd2) ? c_v  : a_v;
    assign o_l  = (sel == 2'd1) ? b_l  : (sel == 2'd2) ? c_l  : a_l;
    assign o_ov = (sel == 2'd1) ? b_ov : (sel == 2'd2) ? c_ov : a_ov;
    assign o_d  = (sel == 2'd1) ? b_d  : (sel == 2'd2) ? c_d  : a_d;

    typedef struct packed {
        logic [1:0]  sel;
        logic [2:0]  pval;
        logic [35:0] e1;
        logic [35:0] e2;
    } vec_t;

    int checks = 0;
    int failures = 0;

    logic [2:0]  samp [512];
    logic [35:0] got_frames [8];
    logic [3:0]  cur_words [9];
    int          exp_win [16];
    int n, wcount, busy, pend_clear, exp_ov, frames, cur_n, nexp;
    int rmode, stall_cnt, prev_stall, integ;
    logic [3:0] prev_d;
    logic       prev_l;
    logic [2:0] inv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int sbit(input int m, input int ch);
        if (m < 0) return 0;
        return (samp[m][ch] ^ inv[ch]) ? 1 : 0;
    endfunction

    // count of coincidences for one output word of window win, saturated to 4 bits
    function automatic int exp_word(input int win, input int word);
        int p = word / 3;
        int d = word % 3 - 1;
        int q = 0, ci = 0, cj = 0, sum = 0;
        for (int a = 0; a < 2; a++)
            for (int b = a + 1; b < 3; b++) begin
                if (q == p) begin ci = a; cj = b; end
                q++;
            end
        for (int t = win * integ; t < (win + 1) * integ; t++) begin
            if (d >= 0) sum += sbit(t - d, ci) & sbit(t, cj);
            else        sum += sbit(t, ci) & sbit(t + d, cj);
        end
        return (sum > 15) ? 15 : sum;
    endfunction

    task automatic step();
        @(negedge clki);
        case (rmode)
            0: ready = 1'b1;
            1: ready = 1'($urandom_range(0, 1));
            2: ready = 1'b0;
            default: begin
                if (cur_n == 4 && stall_cnt < 2 && o_v) begin
                    ready = 1'b0;
                    stall_cnt++;
                end else ready = 1'b1;
            end
        endcase
        if (o_ip) begin
            if (busy != 0) exp_ov = 1;
            else begin
                busy = 1;
                if (nexp < 16) exp_win[nexp] = wcount;
                nexp++;
            end
            wcount++;
        end
        if (pend_clear != 0) begin
            busy = 0;
            pend_clear = 0;
        end
        check("valid_vs_model", 32'(o_v), busy);
        if (prev_stall != 0) begin
            check("stall_data", 32'(o_d), 32'(prev_d));
            check("stall_last", 32'(o_l), 32'(prev_l));
        end
        prev_stall = (o_v && !ready) ? 1 : 0;
        prev_d = o_d;
        prev_l = o_l;
        if (o_v && ready) begin
            check($sformatf("last_flag_w%0d", cur_n), 32'(o_l), 32'(cur_n == 8));
            cur_words[cur_n] = o_d;
            cur_n++;
            if (cur_n == 9) begin
                for (int w = 0; w < 9; w++)
                    check($sformatf("frame%0d_word%0d", frames, w), 32'(cur_words[w]),
                          (frames < nexp && frames < 16) ? exp_word(exp_win[frames], w) : 999);
                if (frames < 8)
                    for (int w = 0; w < 9; w++) got_frames[frames][w*4 +: 4] = cur_words[w];
                frames++;
                cur_n = 0;
                pend_clear = 1;
            end
        end
        if (o_sp) begin
            n++;
            pulse = samp[(n < 512) ? n : 511];
        end
    endtask

    task automatic run_frames(input int nf, input int maxc);
        int c = 0;
        while (frames < nf && c < maxc) begin
            step();
            c++;
        end
        check("frames_done", frames, nf);
    endtask

    task automatic do_reset(input int s, input int rm);
        sel   = 2'(s);
        integ = (s == 1) ? 20 : 8;
        inv   = (s == 2) ? 3'b111 : 3'b000;
        rmode = rm;
        rst_n = 1'b0;
        pulse = samp[0];
        ready = (rm == 2) ? 1'b0 : 1'b1;
        repeat (3) @(negedge clki);
        check("rst_valid", 32'(o_v), 0);
        check("rst_last", 32'(o_l), 0);
        check("rst_data", 32'(o_d), 0);
        check("rst_overrun", 32'(o_ov), 0);
        check("rst_sample_pulse", 32'(o_sp), 0);
        check("rst_integ_pulse", 32'(o_ip), 0);
        n = 0; wcount = 0; busy = 0; pend_clear = 0; exp_ov = 0;
        frames = 0; cur_n = 0; nexp = 0; stall_cnt = 0; prev_stall = 0;
        rst_n = 1'b1;
    endtask

    task automatic fill_random(input int dense);
        for (int k = 0; k < 512; k++)
            samp[k] = (dense != 0 && $urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl [7];
        int cnt;
        tbl[0] = '{2'd0, 3'b111, 36'h787787787, 36'h888888888};
        tbl[1] = '{2'd0, 3'b011, 36'h000000787, 36'h000000888};
        tbl[2] = '{2'd0, 3'b101, 36'h000787000, 36'h000888000};
        tbl[3] = '{2'd0, 3'b110, 36'h787000000, 36'h888000000};
        tbl[4] = '{2'd2, 3'b000, 36'h787787787, 36'h888888888};
        tbl[5] = '{2'd2, 3'b111, 36'h000000000, 36'h000000000};
        tbl[6] = '{2'd1, 3'b111, 36'hFFFFFFFFF, 36'hFFFFFFFFF};

        rst_n = 1'b0; pulse = '0; ready = 1'b0; sel = '0; rmode = 0;
        integ = 8; inv = '0; prev_d = '0; prev_l = 1'b0;
        n = 0; wcount = 0; busy = 0; pend_clear = 0; exp_ov = 0;
        frames = 0; cur_n = 0; nexp = 0; stall_cnt = 0; prev_stall = 0;

        // constant-input vectors: two frames each against literal expectations
        for (int t = 0; t < 7; t++) begin
            for (int k = 0; k < 512; k++) samp[k] = tbl[t].pval;
            do_reset(int'(tbl[t].sel), 0);
            run_frames(2, 400);
            for (int w = 0; w < 9; w++) begin
                check($sformatf("tbl%0d_f1_w%0d", t, w), 32'(got_frames[0][w*4 +: 4]), 32'(tbl[t].e1[w*4 +: 4]));
                check($sformatf("tbl%0d_f2_w%0d", t, w), 32'(got_frames[1][w*4 +: 4]), 32'(tbl[t].e2[w*4 +: 4]));
            end
            check("tbl_overrun", 32'(o_ov), 0);
        end

        // single coincidence at lag +1 on pair 0-1
        for (int k = 0; k < 512; k++) samp[k] = 3'b000;
        samp[2] = 3'b001;
        samp[3] = 3'b010;
        do_reset(0, 0);
        run_frames(1, 200);
        for (int w = 0; w < 9; w++)
            check($sformatf("lag_w%0d", w), 32'(got_frames[0][w*4 +: 4]), (w == 2) ? 1 : 0);

        // 1-0-0-1 ready pattern at word 4
        fill_random(0);
        do_reset(0, 3);
        run_frames(2, 300);
        check("stall_seen", stall_cnt, 2);

        // ready held low over two window ends
        fill_random(0);
        do_reset(0, 2);
        repeat (80) step();
        check("ovr_sticky", 32'(o_ov), 1);
        check("ovr_model", 32'(o_ov), exp_ov);
        rmode = 0;
        run_frames(2, 200);
        check("ovr_after", 32'(o_ov), 1);

        // reset while word 4 is on the port
        fill_random(0);
        do_reset(0, 0);
        cnt = 0;
        while (!(frames == 0 && cur_n == 4) && cnt < 200) begin
            step();
            cnt++;
        end
        check("mid_reached", cur_n, 4);
        #1 rst_n = 1'b0;
        #1;
        check("mid_valid_drop", 32'(o_v), 0);
        check("mid_overrun", 32'(o_ov), 0);
        do_reset(0, 0);
        run_frames(2, 200);

        // randomized data and ready on each instance against the model
        for (int s = 0; s < 3; s++) begin
            fill_random((s == 1) ? 1 : 0);
            do_reset(s, 1);
            run_frames((s == 1) ? 2 : 3, 700);
            check($sformatf("rand%0d_overrun", s), 32'(o_ov), exp_ov);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
